// File: rtl/ub_port_arbiter.sv
// Burst-locked round-robin arbiter for the shared unified-buffer port.
// Read responses are tagged with the issuing owner and returned RD_LAT cycles later.
module ub_port_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_grant,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     ub_en,
    output logic                     ub_we,
    output logic [ADDR_W-1:0]        ub_addr,
    output logic [DATA_W-1:0]        ub_wdata,
    input  logic [DATA_W-1:0]        ub_rdata,
    output logic                     arb_busy,
    output logic [1:0]               arb_owner
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                         state;
    logic                           wr_q;
    logic [ADDR_W-1:0]              base_q;
    logic [LEN_W-1:0]               len_q;
    logic [LEN_W-1:0]               beat_q;
    logic [1:0]                     win;
    logic                           win_vld;
    logic [NREQ-1:0]                own_oh;
    logic [NREQ-1:0]                rd_tag;
    logic [RD_LAT-1:0][NREQ-1:0]    tag_pipe;
    int                             idx;

    // Scan from the farthest candidate down so the nearest one after the
    // last owner is the final assignment.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(arb_owner) + k) % NREQ;
            if (req_valid[idx]) begin
                win     = 2'(idx);
                win_vld = 1'b1;
            end
        end
    end

    assign own_oh    = NREQ'(1) << arb_owner;
    assign arb_busy  = (state == BURST);
    assign ub_en     = arb_busy && req_valid[arb_owner];
    assign ub_we     = ub_en && wr_q;
    assign ub_addr   = ub_en ? base_q + ADDR_W'(beat_q) : '0;
    assign ub_wdata  = ub_en ? req_wdata[arb_owner*DATA_W +: DATA_W] : '0;
    assign req_grant = ub_en ? own_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            arb_owner <= 2'(NREQ-1);
            wr_q      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    arb_owner <= win;
                    wr_q      <= req_wr[win];
                    base_q    <= req_addr[win*ADDR_W +: ADDR_W];
                    len_q     <= req_len[win*LEN_W +: LEN_W];
                    beat_q    <= '0;
                    state     <= BURST;
                end
                BURST: if (ub_en) begin
                    if (beat_q == len_q) begin
                        beat_q <= '0;
                        state  <= IDLE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner tag travels alongside the read so responses survive re-arbitration.
    assign rd_tag = (ub_en && !wr_q) ? own_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_pipe <= '0;
        else        tag_pipe <= (tag_pipe << NREQ) | (RD_LAT*NREQ)'(rd_tag);
    end

    assign rsp_valid = tag_pipe[RD_LAT-1];
    assign rsp_rdata = (|rsp_valid) ? ub_rdata : '0;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Bench for ub_port_arbiter: directed tables/sequences plus random traffic
// against a burst-list reference model.
module tb_ub_port_arbiter;
    localparam int NREQ = 3, ADDR_W = 9, DATA_W = 256, LEN_W = 8, RD_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NREQ-1:0]        req_valid, req_wr, req_grant, rsp_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]      rsp_rdata, ub_wdata, ub_rdata;
    logic                   ub_en, ub_we, arb_busy;
    logic [ADDR_W-1:0]      ub_addr;
    logic [1:0]             arb_owner;

    logic [ADDR_W-1:0] a_addr  [NREQ];
    logic [LEN_W-1:0]  a_len   [NREQ];
    logic [DATA_W-1:0] a_wdata [NREQ];

    always_comb begin
        req_addr = '0; req_len = '0; req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = a_addr[i];
            req_len[i*LEN_W +: LEN_W]     = a_len[i];
            req_wdata[i*DATA_W +: DATA_W] = a_wdata[i];
        end
    end

    ub_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ub_en(ub_en), .ub_we(ub_we), .ub_addr(ub_addr), .ub_wdata(ub_wdata),
        .ub_rdata(ub_rdata), .arb_busy(arb_busy), .arb_owner(arb_owner));

    always #5 clk = ~clk;

    // Reference model: current burst as a list of remaining addresses,
    // outstanding reads as (due cycle, owner) pairs.
    bit  m_busy, m_wr;
    int  m_owner;
    int  m_addrs[$];
    int  r_due[$], r_own[$];
    int  cyc;
    int  n_cmp, n_bad;

    logic             s_en, s_we, s_busy;
    logic [ADDR_W-1:0] s_addr;
    logic [NREQ-1:0]  s_grant, s_rsp;
    logic [1:0]       s_owner;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkw(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic e_en;
        logic [NREQ-1:0] e_grant, e_rsp;
        ub_rdata = {8{$urandom}};
        e_en    = m_busy && req_valid[m_owner];
        e_grant = e_en ? (3'b001 << m_owner) : 3'b000;
        e_rsp   = '0;
        foreach (r_due[i]) if (r_due[i] == cyc) e_rsp |= 3'b001 << r_own[i];
        @(negedge clk);
        s_en = ub_en; s_we = ub_we; s_addr = ub_addr; s_grant = req_grant;
        s_rsp = rsp_valid; s_busy = arb_busy; s_owner = arb_owner;
        chk("ub_en", 32'(ub_en), 32'(e_en));
        chk("ub_we", 32'(ub_we), 32'(e_en && m_wr));
        chk("req_grant", 32'(req_grant), 32'(e_grant));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("arb_busy", 32'(arb_busy), 32'(m_busy));
        chk("arb_owner", 32'(arb_owner), 32'(m_owner));
        if (e_en) begin
            chk("ub_addr", 32'(ub_addr), 32'(m_addrs[0]));
            chkw("ub_wdata", ub_wdata, a_wdata[m_owner]);
        end
        if (e_rsp != 0) chkw("rsp_rdata", rsp_rdata, ub_rdata);
        @(posedge clk);
        while (r_due.size() > 0 && r_due[0] <= cyc) begin
            void'(r_due.pop_front()); void'(r_own.pop_front());
        end
        if (m_busy) begin
            if (e_en) begin
                if (!m_wr) begin r_due.push_back(cyc + RD_LAT); r_own.push_back(m_owner); end
                void'(m_addrs.pop_front());
                if (m_addrs.size() == 0) m_busy = 1'b0;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int id;
                id = (m_owner + k) % NREQ;
                if (req_valid[id]) begin
                    m_owner = id; m_wr = req_wr[id]; m_addrs = {};
                    for (int j = 0; j <= int'(a_len[id]); j++)
                        m_addrs.push_back((int'(a_addr[id]) + j) % (1 << ADDR_W));
                    m_busy = 1'b1;
                    break;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        logic z;
        rst_n = 1'b0;
        #1;
        z = |{req_grant, rsp_valid, rsp_rdata, ub_en, ub_we, ub_addr, ub_wdata, arb_busy};
        chk("rst_outs_zero", 32'(z), 32'd0);
        chk("rst_owner", 32'(arb_owner), 32'(NREQ-1));
        m_busy = 1'b0; m_wr = 1'b0; m_owner = NREQ-1; m_addrs = {}; r_due = {}; r_own = {};
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] v;
        logic       en;
        logic       we;
        logic [8:0] addr;
        logic [2:0] grant;
        logic       busy;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int q[$], gc[$], adr[$], nr1, nr2, ng1, ng2, nrsp, first;
        logic prev_rd;
        logic [6:0] stall_v, stall_en;
        n_cmp = 0; n_bad = 0; cyc = 0;
        req_valid = '0; req_wr = '0; ub_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = '0; a_len[i] = '0; a_wdata[i] = {8{$urandom}};
        end
        #2;
        do_reset();

        // Single write burst, table-driven
        tbl[0] = '{3'b010, 1'b0, 1'b0, 9'h000, 3'b000, 1'b0};
        for (int i = 1; i <= 4; i++) tbl[i] = '{3'b010, 1'b1, 1'b1, 9'(9'h010 + i - 1), 3'b010, 1'b1};
        tbl[5] = '{3'b000, 1'b0, 1'b0, 9'h000, 3'b000, 1'b0};
        req_wr[1] = 1'b1; a_addr[1] = 9'h010; a_len[1] = 8'd3;
        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].v;
            cycle();
            chk("tbl_en", 32'(s_en), 32'(tbl[i].en));
            chk("tbl_we", 32'(s_we), 32'(tbl[i].we));
            chk("tbl_grant", 32'(s_grant), 32'(tbl[i].grant));
            chk("tbl_busy", 32'(s_busy), 32'(tbl[i].busy));
            if (tbl[i].en) chk("tbl_addr", 32'(s_addr), 32'(tbl[i].addr));
            if (s_grant[1]) a_wdata[1] = {8{$urandom}};
        end

        // Round-robin fairness with single-beat bursts
        do_reset();
        req_valid = 3'b111; req_wr = 3'b111;
        for (int i = 0; i < NREQ; i++) a_len[i] = 8'd0;
        q = {}; gc = {};
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (s_grant != 0) begin q.push_back(int'(s_owner)); gc.push_back(c); end
        end
        chk("rr_count", 32'(q.size()), 32'd6);
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            chk("rr_order", 32'(q[i]), 32'(i % 3));
            if (i > 0) chk("rr_gap", 32'(gc[i] - gc[i-1]), 32'd2);
        end

        // Read with address wrap, response one cycle after each beat
        do_reset();
        req_valid = 3'b100; req_wr = 3'b000; a_addr[2] = 9'h1FE; a_len[2] = 8'd2;
        adr = {}; nrsp = 0; ng2 = 0; prev_rd = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("rd_lag", 32'(s_rsp[2]), 32'(prev_rd));
            prev_rd = s_en;
            if (s_en) adr.push_back(int'(s_addr));
            if (s_rsp[2]) nrsp++;
            if (s_grant[2]) ng2++;
            if (ng2 == 3) req_valid[2] = 1'b0;
        end
        chk("wrap_beats", 32'(adr.size()), 32'd3);
        if (adr.size() == 3) begin
            chk("wrap_a0", 32'(adr[0]), 32'h1FE);
            chk("wrap_a1", 32'(adr[1]), 32'h1FF);
            chk("wrap_a2", 32'(adr[2]), 32'h000);
        end
        chk("wrap_rsp", 32'(nrsp), 32'd3);

        // Stall mid-burst while another requester waits
        do_reset();
        req_wr = 3'b001; a_addr[0] = 9'h040; a_len[0] = 8'd3; a_len[1] = 8'd0;
        stall_v = 7'b1100111; stall_en = 7'b1100110;
        req_valid = 3'b011; adr = {}; ng1 = 0;
        for (int c = 0; c < 7; c++) begin
            req_valid[0] = stall_v[c];
            cycle();
            chk("stall_en", 32'(s_en), 32'(stall_en[c]));
            if (s_en) adr.push_back(int'(s_addr));
            if (s_grant[1]) ng1++;
            if (s_grant[0]) a_wdata[0] = {8{$urandom}};
        end
        chk("stall_req1", 32'(ng1), 32'd0);
        chk("stall_beats", 32'(adr.size()), 32'd4);
        for (int i = 0; i < 4 && i < adr.size(); i++) chk("stall_addr", 32'(adr[i]), 32'(9'h040 + i));

        // Late read response across handoff to a writer
        do_reset();
        req_wr = 3'b100; a_len[1] = 8'd0; a_len[2] = 8'd0;
        req_valid = 3'b110; nr1 = 0; nr2 = 0; ng2 = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (s_grant[1]) req_valid[1] = 1'b0;
            if (s_grant[2]) begin req_valid[2] = 1'b0; ng2++; end
            if (s_rsp[1]) nr1++;
            if (s_rsp[2]) nr2++;
        end
        chk("late_rsp1", 32'(nr1), 32'd1);
        chk("late_rsp2", 32'(nr2), 32'd0);
        chk("late_grant2", 32'(ng2), 32'd1);

        // Reset during beat 2 of an 8-beat read
        do_reset();
        req_wr = 3'b000; a_addr[1] = 9'h020; a_len[1] = 8'd7; req_valid = 3'b010;
        cycle(); cycle();
        do_reset();
        req_valid = 3'b001; req_wr = 3'b001; a_len[0] = 8'd0;
        nrsp = 0; first = -1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (s_rsp != 0) nrsp++;
            if (s_grant != 0 && first < 0) first = int'(s_owner);
            if (s_grant[0]) req_valid = 3'b000;
        end
        chk("rst_no_rsp", 32'(nrsp), 32'd0);
        chk("rst_first_owner", 32'(first), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom % 4) != 0;
                req_wr[i]    = $urandom % 2;
                a_addr[i]    = 9'($urandom);
                a_len[i]     = 8'($urandom % 6);
                a_wdata[i]   = {8{$urandom}};
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
